// File: rtl/neuron_backward.sv
// neuron_backward: backward pass of a single neuron. For each input channel it
// computes the propagated error e = sat((delta*w) >>> WEIGHT_FRACTION) and the
// updated weight w' = sat(w - ((delta*x) >>> LR_SHIFT)), one channel per cycle
// through one shared multiplier pair. Results collect in shadow registers and
// are published all at once, so the outputs never show a partial update.
module neuron_backward #(
    parameter int NEURON_NUM      = 5,
    parameter int INPUT_SIZE      = 9,
    parameter int WEIGHT_SIZE     = 17,
    parameter int WEIGHT_FRACTION = 3,
    parameter int DELTA_SIZE      = 10,
    parameter int LR_SHIFT        = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic signed [DELTA_SIZE-1:0]        delta,
    input  logic [NEURON_NUM*INPUT_SIZE-1:0]    inputs,
    input  logic [NEURON_NUM*WEIGHT_SIZE-1:0]   weights,
    output logic [NEURON_NUM*DELTA_SIZE-1:0]    out_errors,
    output logic [NEURON_NUM*WEIGHT_SIZE-1:0]   out_weights,
    output logic                                out_valid,
    output logic                                busy
);

    localparam int EP_W = DELTA_SIZE + WEIGHT_SIZE;   // full delta*w product
    localparam int GP_W = DELTA_SIZE + INPUT_SIZE;    // full delta*x product
    localparam int WD_W = WEIGHT_SIZE + 1;            // weight subtraction width
    localparam int K_W  = (NEURON_NUM > 1) ? $clog2(NEURON_NUM) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                             state_q, state_d;
    logic [K_W-1:0]                     k_q;
    logic signed [DELTA_SIZE-1:0]       delta_q;
    logic [NEURON_NUM*INPUT_SIZE-1:0]   inputs_q;
    logic [NEURON_NUM*WEIGHT_SIZE-1:0]  weights_q;
    logic [NEURON_NUM*DELTA_SIZE-1:0]   err_sh_q, out_errors_q;
    logic [NEURON_NUM*WEIGHT_SIZE-1:0]  wt_sh_q, out_weights_q;
    logic                               out_valid_q;

    logic signed [INPUT_SIZE-1:0]       x_k;
    logic signed [WEIGHT_SIZE-1:0]      w_k;
    logic signed [EP_W-1:0]             eprod;
    logic signed [GP_W-1:0]             gprod;
    logic signed [WD_W-1:0]             wdiff;
    logic signed [DELTA_SIZE-1:0]       e_k;
    logic signed [WEIGHT_SIZE-1:0]      wn_k;
    logic                               last_k;

    // Clamp a shifted error product into the DELTA_SIZE signed range.
    function automatic logic signed [DELTA_SIZE-1:0] sat_err(input logic signed [EP_W-1:0] v);
        logic [EP_W-DELTA_SIZE:0] top;
        top = v[EP_W-1:DELTA_SIZE-1];
        if (top == '0 || top == '1)
            sat_err = v[DELTA_SIZE-1:0];
        else if (v[EP_W-1])
            sat_err = {1'b1, {(DELTA_SIZE-1){1'b0}}};
        else
            sat_err = {1'b0, {(DELTA_SIZE-1){1'b1}}};
    endfunction

    // Clamp the widened weight difference into the WEIGHT_SIZE signed range.
    function automatic logic signed [WEIGHT_SIZE-1:0] sat_wt(input logic signed [WD_W-1:0] v);
        logic [WD_W-WEIGHT_SIZE:0] top;
        top = v[WD_W-1:WEIGHT_SIZE-1];
        if (top == '0 || top == '1)
            sat_wt = v[WEIGHT_SIZE-1:0];
        else if (v[WD_W-1])
            sat_wt = {1'b1, {(WEIGHT_SIZE-1){1'b0}}};
        else
            sat_wt = {1'b0, {(WEIGHT_SIZE-1){1'b1}}};
    endfunction

    // Shared datapath for channel k: full-width products, floor shifts, saturation.
    assign x_k    = inputs_q[k_q*INPUT_SIZE +: INPUT_SIZE];
    assign w_k    = weights_q[k_q*WEIGHT_SIZE +: WEIGHT_SIZE];
    assign eprod  = EP_W'(delta_q) * EP_W'(w_k);
    assign gprod  = GP_W'(delta_q) * GP_W'(x_k);
    assign e_k    = sat_err(eprod >>> WEIGHT_FRACTION);
    // The shifted gradient is bounded well inside WD_W bits, so narrowing is lossless.
    assign wdiff  = WD_W'(w_k) - WD_W'(gprod >>> LR_SHIFT);
    assign wn_k   = sat_wt(wdiff);
    assign last_k = (k_q == K_W'(NEURON_NUM - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic: start is honoured only from IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (last_k) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand latch, channel counter, shadow accumulation and result publish.
    always_ff @(posedge clk) begin
        if (!rst) begin
            k_q           <= '0;
            delta_q       <= '0;
            inputs_q      <= '0;
            weights_q     <= '0;
            err_sh_q      <= '0;
            wt_sh_q       <= '0;
            out_errors_q  <= '0;
            out_weights_q <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        delta_q   <= delta;
                        inputs_q  <= inputs;
                        weights_q <= weights;
                        k_q       <= '0;
                    end
                end
                CALC: begin
                    err_sh_q[k_q*DELTA_SIZE +: DELTA_SIZE]   <= e_k;
                    wt_sh_q[k_q*WEIGHT_SIZE +: WEIGHT_SIZE]  <= wn_k;
                    k_q <= last_k ? '0 : k_q + K_W'(1);
                end
                DONE: begin
                    out_errors_q  <= err_sh_q;
                    out_weights_q <= wt_sh_q;
                    out_valid_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_errors  = out_errors_q;
    assign out_weights = out_weights_q;
    assign out_valid   = out_valid_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_neuron_backward.sv
// Bench for neuron_backward: directed and randomized operations checked
// against an integer reference model of the backward-pass arithmetic.
module tb_neuron_backward;

    localparam int NN = 5;
    localparam int IS = 9;
    localparam int WS = 17;
    localparam int WF = 3;
    localparam int DS = 10;
    localparam int LR = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic signed [DS-1:0] delta;
    logic [NN*IS-1:0]     inputs;
    logic [NN*WS-1:0]     weights;
    logic [NN*DS-1:0]     out_errors;
    logic [NN*WS-1:0]     out_weights;
    logic                 out_valid;
    logic                 busy;

    int total = 0;
    int bad   = 0;
    int vcount = 0;

    int dv;
    int xv[NN];
    int wv[NN];
    int ee[NN];
    int ew[NN];
    int hold_e[NN];
    int hold_w[NN];

    neuron_backward #(
        .NEURON_NUM(NN), .INPUT_SIZE(IS), .WEIGHT_SIZE(WS),
        .WEIGHT_FRACTION(WF), .DELTA_SIZE(DS), .LR_SHIFT(LR)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .delta(delta),
        .inputs(inputs), .weights(weights),
        .out_errors(out_errors), .out_weights(out_weights),
        .out_valid(out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (out_valid === 1'b1) vcount++;

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // floor(p / 2^s), written as division with correction toward -inf
    function automatic longint floor_pow2(longint p, int s);
        longint d, q;
        d = longint'(1) << s;
        q = p / d;
        if ((p % d != 0) && (p < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int clamp(longint v, int w);
        longint lo, hi;
        lo = -(longint'(1) << (w - 1));
        hi = (longint'(1) << (w - 1)) - 1;
        if (v < lo) return int'(lo);
        if (v > hi) return int'(hi);
        return int'(v);
    endfunction

    task automatic calc_expected();
        for (int i = 0; i < NN; i++) begin
            ee[i] = clamp(floor_pow2(longint'(dv) * wv[i], WF), DS);
            ew[i] = clamp(longint'(wv[i]) - floor_pow2(longint'(dv) * xv[i], LR), WS);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input int e[NN], input int w[NN]);
        for (int i = 0; i < NN; i++) begin
            chk($sformatf("%s.err%0d", tag, i), $signed(out_errors[i*DS +: DS]), e[i]);
            chk($sformatf("%s.wt%0d", tag, i), $signed(out_weights[i*WS +: WS]), w[i]);
        end
    endtask

    task automatic drive_ops();
        delta = dv[DS-1:0];
        for (int i = 0; i < NN; i++) begin
            inputs[i*IS +: IS]  = xv[i][IS-1:0];
            weights[i*WS +: WS] = wv[i][WS-1:0];
        end
    endtask

    task automatic rand_ops();
        dv = int'($urandom_range(0, 1023)) - 512;
        if ($urandom_range(0, 3) == 0) dv = ($urandom_range(0, 1) == 0) ? 511 : -512;
        for (int i = 0; i < NN; i++) begin
            xv[i] = int'($urandom_range(0, 511)) - 256;
            wv[i] = int'($urandom_range(0, 131071)) - 65536;
            if ($urandom_range(0, 4) == 0) wv[i] = ($urandom_range(0, 1) == 0) ? 65535 : -65536;
        end
    endtask

    // One operation; inj_at > 0 raises a second start with other operands
    // just before edge E(inj_at), which the DUT must ignore.
    task automatic run_op(input string tag, input int inj_at);
        int v0;
        int lat;
        calc_expected();
        v0 = vcount;
        drive_ops();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ".busy_e0"}, busy, 1);
        chk({tag, ".valid_e0"}, out_valid, 0);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            if (c == inj_at) begin
                for (int i = 0; i < NN; i++) begin
                    inputs[i*IS +: IS]  = IS'($urandom);
                    weights[i*WS +: WS] = WS'($urandom);
                end
                delta = DS'(dv + 37);
                start = 1'b1;
            end
            tick();
            start = 1'b0;
            if (out_valid === 1'b1) begin
                lat = c;
                break;
            end
            chk({tag, ".busy_run"}, busy, 1);
            chk_vec({tag, ".hold"}, hold_e, hold_w);
        end
        chk({tag, ".latency"}, lat, NN + 1);
        chk_vec({tag, ".res"}, ee, ew);
        chk({tag, ".busy_done"}, busy, 0);
        hold_e = ee;
        hold_w = ew;
        tick();
        chk({tag, ".valid_drop"}, out_valid, 0);
        repeat (8) tick();
        chk({tag, ".pulses"}, vcount - v0, 1);
        chk_vec({tag, ".kept"}, hold_e, hold_w);
    endtask

    initial begin
        int v0;
        rst = 1'b0;
        start = 1'b0;
        delta = '0;
        inputs = '0;
        weights = '0;
        for (int i = 0; i < NN; i++) begin
            hold_e[i] = 0;
            hold_w[i] = 0;
        end

        // Reset then idle
        repeat (3) tick();
        rst = 1'b1;
        chk("rst.busy", busy, 0);
        chk("rst.valid", out_valid, 0);
        chk_vec("rst", hold_e, hold_w);
        v0 = vcount;
        repeat (20) tick();
        chk("idle.pulses", vcount - v0, 0);

        // Nominal vector
        dv = 16;
        xv = '{-40, 43, 103, 7, -150};
        wv = '{560, -40, -8, 80, -160};
        run_op("nominal", 0);

        // Positive saturation of both results on channel 0
        dv = 511;
        xv = '{-256, 1, -1, 100, -100};
        wv = '{65535, 3, -3, 1000, -1000};
        run_op("sat_pos", 0);

        // Negative delta: error clamps high, weight clamps low
        dv = -512;
        xv = '{-256, 255, -256, 0, 17};
        wv = '{-65536, 65535, -65536, 12345, -7};
        run_op("sat_neg", 0);

        // Zero delta leaves weights unchanged and errors zero
        rand_ops();
        dv = 0;
        run_op("zero_delta", 0);

        // Second start two cycles into an operation
        rand_ops();
        run_op("busy_start", 2);

        // Start presented in the DONE cycle
        rand_ops();
        run_op("done_start", NN + 1);

        // Reset asserted at E3 of an operation
        rand_ops();
        drive_ops();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        v0 = vcount;
        tick();
        rst = 1'b1;
        for (int i = 0; i < NN; i++) begin
            hold_e[i] = 0;
            hold_w[i] = 0;
        end
        chk("midrst.busy", busy, 0);
        chk("midrst.valid", out_valid, 0);
        chk_vec("midrst", hold_e, hold_w);
        repeat (10) tick();
        chk("midrst.pulses", vcount - v0, 0);
        rand_ops();
        run_op("after_rst", 0);

        // Randomized operations
        for (int n = 0; n < 12; n++) begin
            rand_ops();
            run_op($sformatf("rand%0d", n), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
